// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants and arithmetic for the PCM-to-PDM modulator.
// Widths derive from the PCM width; sat_add clamps instead of wrapping.
package pdm_pkg;

  localparam int PCM_W = 16;
  localparam int RATE  = 10;

  function automatic int acc_w(input int n);
    return n + 4;
  endfunction

  function automatic int fs_of(input int n);
    return 1 << (n - 1);
  endfunction

  function automatic int lim_of(input int n);
    return 1 << (n + 2);
  endfunction

  localparam int FS      = fs_of(PCM_W);
  localparam int ACC_W   = acc_w(PCM_W);
  localparam int SAT_MAX = lim_of(PCM_W);
  localparam int SAT_MIN = -SAT_MAX;

  // a + b, clamped to +/-lim
  function automatic int sat_add(
    input int a,
    input int b,
    input int lim
  );
    int s;
    s = a + b;
    if (s > lim) begin
      return lim;
    end
    if (s < -lim) begin
      return -lim;
    end
    return s;
  endfunction

endpackage

// File: rtl/pdm_mod_sdm_loop.sv
// sdm_loop: sigma-delta loop arithmetic and the registered PDM bit.
// PDM_MOD_ORDER2_EN selects the second-order loop; default is first order.
import pdm_pkg::*;

module sdm_loop #(
  parameter int N = PCM_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic signed [N-1:0] cur,
  output logic                pdm_out
);

  localparam int AW  = acc_w(N);
  localparam int FSV = fs_of(N);
  localparam int LIM = lim_of(N);

  logic signed [AW-1:0] acc1;
  int fb;
  int a1_next;

`ifdef PDM_MOD_ORDER2_EN
  logic signed [AW-1:0] acc2;
  int a2_next;

  // next loop state, second order
  always_comb begin
    fb      = pdm_out ? FSV : -FSV;
    a1_next = sat_add(int'(acc1), int'(cur) - fb, LIM);
    a2_next = sat_add(int'(acc2), a1_next - fb, LIM);
  end

  // advance both integrators once per bit strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      acc1    <= '0;
      acc2    <= '0;
      pdm_out <= 1'b0;
    end else if (we) begin
      acc1    <= AW'(a1_next);
      acc2    <= AW'(a2_next);
      pdm_out <= (a2_next >= 0);
    end
  end
`else
  // next loop state, first order
  always_comb begin
    fb      = pdm_out ? FSV : -FSV;
    a1_next = sat_add(int'(acc1), int'(cur) - fb, LIM);
  end

  // advance the integrator once per bit strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      acc1    <= '0;
      pdm_out <= 1'b0;
    end else if (we) begin
      acc1    <= AW'(a1_next);
      pdm_out <= (a1_next >= 0);
    end
  end
`endif

endmodule

// File: rtl/pdm_mod.sv
// pdm_mod: PCM-to-PDM modulator top; handshake, hold register, framing.
// Loop order selected by PDM_MOD_ORDER2_EN (see sdm_loop).
import pdm_pkg::*;

module pdm_mod #(
  parameter int N = PCM_W,
  parameter int R = RATE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         pdm_out,
  output logic         underrun
);

  localparam logic [3:0] LAST = 4'(R - 1);

  logic [N-1:0]        hold;
  logic                full;
  logic signed [N-1:0] cur;
  logic [3:0]          cnt;
  logic                boundary;
  logic                accept;

  assign in_ready = !full;
  assign accept   = in_valid && !full;
  assign boundary = we && (cnt == LAST);

  // handshake and holding register; live regardless of we
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      full <= 1'b0;
    end else if (accept) begin
      hold <= in_data;
      full <= 1'b1;
    end else if (boundary) begin
      full <= 1'b0;
    end
  end

  // frame counter, sample handover and underrun pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cur      <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (we) begin
        cnt <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
      end
      if (boundary) begin
        if (full) begin
          cur <= hold;
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

  sdm_loop #(
    .N (N)
  ) u_loop (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .cur     (cur),
    .pdm_out (pdm_out)
  );

endmodule

// File: tb/tb_pdm_mod.sv
// tb_pdm_mod: directed self-checking bench for pdm_mod (N=16, R=10).
// Outputs sampled 1 time unit after the rising edge; inputs driven there too.
module tb_pdm_mod;

  localparam int R = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        pdm_out;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  pdm_mod #(
    .N (16),
    .R (R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pdm_out  (pdm_out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_rst();
    rst      = 1'b1;
    we       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_rst();
    checks++;
    if (pdm_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_pdm: got %b want 0", pdm_out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_underrun: got %b want 0", underrun);
    end
  endtask

  task automatic test_idle_seq();
    logic [7:0] pat;
    int ones;
    int urun;
    pat  = 8'b1010_1011;
    ones = 0;
    urun = 0;
    apply_rst();
    we = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (pdm_out) ones++;
      if (underrun) urun++;
`ifndef PDM_MOD_ORDER2_EN
      if (i < 8) begin
        checks++;
        if (pdm_out !== pat[i]) begin
          errors++;
          $display("FAIL idle_bit%0d: got %b want %b", i, pdm_out, pat[i]);
        end
      end
`endif
    end
    checks++;
    if (ones < 498 || ones > 502) begin
      errors++;
      $display("FAIL idle_density: got %0d ones want 500+-2", ones);
    end
    checks++;
    if (urun != 100) begin
      errors++;
      $display("FAIL idle_underruns: got %0d want 100", urun);
    end
  endtask

  task automatic test_density(
    input int    val,
    input int    lo,
    input int    hi,
    input string name
  );
    int ones;
    int urun;
    ones = 0;
    urun = 0;
    apply_rst();
    we       = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'(val);
    for (int i = 0; i < 10 * R; i++) step();
    for (int i = 0; i < 1000; i++) begin
      step();
      if (pdm_out) ones++;
      if (underrun) urun++;
    end
    in_valid = 1'b0;
    checks++;
    if (ones < lo || ones > hi) begin
      errors++;
      $display("FAIL %s: got %0d ones want %0d..%0d", name, ones, lo, hi);
    end
    checks++;
    if (urun != 0) begin
      errors++;
      $display("FAIL %s_underrun: got %0d want 0", name, urun);
    end
  endtask

  task automatic test_handshake();
    int acc;
    int low;
    int urun;
    acc  = 0;
    low  = 0;
    urun = 0;
    apply_rst();
    we       = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd1000;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_ready_drop: got %b want 0", in_ready);
    end
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        acc++;
      end else begin
        low++;
      end
      step();
      if (!in_ready) in_data = in_data + 16'd7;
      if (underrun) urun++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 10) begin
      errors++;
      $display("FAIL hs_accepts: got %0d want 10", acc);
    end
    checks++;
    if (low != 90) begin
      errors++;
      $display("FAIL hs_ready_low: got %0d want 90", low);
    end
    checks++;
    if (urun != 0) begin
      errors++;
      $display("FAIL hs_underrun: got %0d want 0", urun);
    end
  endtask

  task automatic test_starve();
    int ones;
    int urun;
    int dbl;
    logic prev_u;
    ones   = 0;
    urun   = 0;
    dbl    = 0;
    prev_u = 1'b0;
    apply_rst();
    we       = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd8192;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL starve_full: got ready %b want 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL starve_consume: got ready %b urun %b want 1 0",
               in_ready, underrun);
    end
    for (int i = 0; i < 1000; i++) begin
      step();
      if (pdm_out) ones++;
      if (underrun) urun++;
      if (underrun && prev_u) dbl++;
      prev_u = underrun;
    end
    checks++;
    if (ones < 615 || ones > 635) begin
      errors++;
      $display("FAIL starve_density: got %0d ones want 615..635", ones);
    end
    checks++;
    if (urun != 100 || dbl != 0) begin
      errors++;
      $display("FAIL starve_underruns: got %0d (dbl %0d) want 100 (0)",
               urun, dbl);
    end
  endtask

  task automatic test_we_gate();
    int bad_frz;
    int bad_chg;
    int urun;
    logic prev_we;
    logic prev_pdm;
    bad_frz = 0;
    bad_chg = 0;
    urun    = 0;
    apply_rst();
    we       = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd100;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL gate_accept: got ready %b want 0", in_ready);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (pdm_out !== 1'b0 || underrun !== 1'b0) bad_frz++;
    end
    checks++;
    if (bad_frz != 0) begin
      errors++;
      $display("FAIL gate_frozen: got %0d changes want 0", bad_frz);
    end
    prev_pdm = pdm_out;
    for (int i = 0; i < 200; i++) begin
      we      = (i % 2 == 0);
      prev_we = we;
      step();
      if (!prev_we && pdm_out !== prev_pdm) bad_chg++;
      if (underrun) urun++;
      prev_pdm = pdm_out;
    end
    we = 1'b0;
    checks++;
    if (bad_chg != 0) begin
      errors++;
      $display("FAIL gate_hold: got %0d changes want 0", bad_chg);
    end
    checks++;
    if (urun != 9) begin
      errors++;
      $display("FAIL gate_underruns: got %0d want 9", urun);
    end
  endtask

  task automatic test_reset_mid();
    int early;
    logic [3:0] bits;
    early = 0;
    bits  = '0;
    apply_rst();
    we       = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd16384;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if (pdm_out !== 1'b0 || in_ready !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out: got pdm %b rdy %b urun %b want 0 1 0",
               pdm_out, in_ready, underrun);
    end
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i < 4) bits[i] = pdm_out;
      if (underrun) early++;
    end
`ifndef PDM_MOD_ORDER2_EN
    checks++;
    if (bits !== 4'b1011) begin
      errors++;
      $display("FAIL mid_rst_bits: got %b want 1011", bits);
    end
`endif
    step();
    checks++;
    if (underrun !== 1'b1 || early != 0) begin
      errors++;
      $display("FAIL mid_rst_discard: got urun %b early %0d want 1 0",
               underrun, early);
    end
    in_valid = 1'b1;
    in_data  = 16'h8000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (underrun !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_new: got urun %b rdy %b want 0 1",
               underrun, in_ready);
    end
  endtask

  initial begin
    rst      = 1'b1;
    we       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_idle_seq();
    test_density(32767, 998, 1000, "dens_pos_fs");
    test_density(-32768, 0, 2, "dens_neg_fs");
    test_density(16384, 747, 753, "dens_half");
    test_handshake();
    test_starve();
    test_we_gate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
